// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, NOP encoding,
// opcode field width and the default reset fetch address.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam int unsigned OPCODE_W         = 7;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory requests, a one-entry skid
// buffer for responses arriving under stall, and the IF/ID pipeline register.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                id_valid,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_instr,
  output logic [OPCODE_W-1:0] id_opcode
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  pend_pc, pend_pc_n;
  logic         drop, drop_n;
  logic [31:0]  skid_instr, skid_instr_n;
  logic [31:0]  skid_pc, skid_pc_n;
  logic         id_valid_n;
  logic [31:0]  id_pc_n, id_instr_n;

  assign imem_req  = (state == FETCH) && !redirect_valid;
  assign imem_addr = pc;
  assign id_opcode = id_instr[OPCODE_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      drop       <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= NOP;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_pc    <= pend_pc_n;
      drop       <= drop_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      id_valid   <= id_valid_n;
      id_pc      <= id_pc_n;
      id_instr   <= id_instr_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_pc_n    = pend_pc;
    drop_n       = drop;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    // Default: bubble when decode can accept, otherwise hold the IF/ID register
    id_valid_n   = stall ? id_valid : 1'b0;
    id_pc_n      = id_pc;
    id_instr_n   = id_instr;

    if (redirect_valid) begin
      pc_n       = redirect_pc & ~32'd3;
      id_valid_n = 1'b0;
      case (state)
        FETCH: ;
        WAIT: begin
          // A response in the redirect cycle is the stale one; otherwise mark it for discard
          if (imem_rvalid) begin
            state_n = FETCH;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        HOLD:    state_n = FETCH;
        default: state_n = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_gnt) begin
            pend_pc_n = pc;
            pc_n      = pc + 32'd4;
            state_n   = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_n = FETCH;
            if (drop) begin
              drop_n = 1'b0;
            end else if (!id_valid || !stall) begin
              id_instr_n = imem_rdata;
              id_pc_n    = pend_pc;
              id_valid_n = 1'b1;
            end else begin
              skid_instr_n = imem_rdata;
              skid_pc_n    = pend_pc;
              state_n      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            id_instr_n = skid_instr;
            id_pc_n    = skid_pc;
            id_valid_n = 1'b1;
            state_n    = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;

  instr_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_deliv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Instruction memory contents: fixed word at 0, address-derived pattern elsewhere
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {a[24:0], a[31:25]} ^ 32'h0000_0033;
  endfunction

  // Memory responder state
  bit          pend = 0, pend_stale = 0, resp_now = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  bit          spur_en = 0, keep_on_reset = 0;

  task automatic drive(input bit st, input int rd_mode, input logic [31:0] rpc);
    resp_now = 0;
    if (pend && cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(paddr);
      resp_now    = !pend_stale;
    end else if (spur_en && !pend && $urandom_range(7, 0) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt       = (int'($urandom_range(99, 0)) < gnt_pct);
    stall          = st;
    redirect_valid = (rd_mode == 1) || (rd_mode == 2 && imem_rvalid);
    redirect_pc    = rpc;
    #3;
  endtask

  task automatic tick();
    bit          g;
    logic [31:0] a;
    g = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk); #1;
    if (pend) begin
      if (cnt == 0) pend = 0;
      else cnt--;
    end
    if (reset) begin
      if (keep_on_reset) pend_stale = pend;
      else pend = 0;
    end else if (g) begin
      pend       = 1;
      pend_stale = 0;
      paddr      = a;
      cnt        = int'($urandom_range(lat_max, lat_min)) - 1;
    end
  endtask

  // cond: 0 id_valid, 1 grant, 2 request, 3 id_valid with grant
  task automatic wait_until(input int cond, input bit st, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      drive(st, 0, '0);
      case (cond)
        0:       hit = id_valid;
        1:       hit = imem_req && imem_gnt;
        2:       hit = imem_req;
        default: hit = id_valid && imem_req && imem_gnt;
      endcase
      if (!hit) tick();
    end
    chk({"found_", name}, 32'(hit), 32'd1);
  endtask

  // Transaction-level model: program-order queue of granted fetch addresses,
  // flushed by redirect/reset; every new IF/ID entry must be its head.
  initial begin : compare
    logic [31:0] q[$];
    logic [31:0] exp_pc = TB_RESET_PC;
    bit          owes = 0;
    bit          prev_reset = 1, prev_redirect = 0, prev_stall = 0, prev_valid = 0;
    logic [31:0] prev_pc = '0, prev_instr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        owes   = 0;
        exp_pc = TB_RESET_PC;
      end else begin
        if (prev_reset) begin
          chk("rst_valid", 32'(id_valid), 32'd0);
          chk("rst_pc", id_pc, 32'd0);
          chk("rst_instr", id_instr, NOP);
        end else if (prev_redirect) begin
          chk("redirect_bubble", 32'(id_valid), 32'd0);
        end else if (prev_stall && prev_valid) begin
          chk("stall_hold_valid", 32'(id_valid), 32'd1);
          chk("stall_hold_pc", id_pc, prev_pc);
          chk("stall_hold_instr", id_instr, prev_instr);
        end else if (id_valid) begin
          chk("delivery_pending", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            chk("deliv_pc", id_pc, q[0]);
            chk("deliv_instr", id_instr, memf(q[0]));
            void'(q.pop_front());
          end
          n_deliv++;
        end
        chk("opcode", 32'(id_opcode), 32'(id_instr[6:0]));
        chk("req", 32'(imem_req), 32'(!redirect_valid && !owes && q.size() == 0));
        if (imem_req) chk("addr", imem_addr, exp_pc);
        if (resp_now) owes = 0;
        if (redirect_valid) begin
          q.delete();
          exp_pc = redirect_pc & ~32'd3;
        end else if (imem_req && imem_gnt) begin
          q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
          owes   = 1;
        end
      end
      prev_reset    = reset;
      prev_redirect = redirect_valid;
      prev_stall    = stall;
      prev_valid    = id_valid;
      prev_pc       = id_pc;
      prev_instr    = id_instr;
    end
  end

  initial begin : driver
    logic [31:0] hold_pc, rec, rpc;
    bit          st;
    int          rd;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset release, back-to-back fetch with 1-cycle response
    drive(0, 0, '0);
    chk("s1_req", 32'(imem_req), 32'd1);
    chk("s1_addr", imem_addr, 32'h0);
    tick();
    drive(0, 0, '0);
    chk("s1_wait_valid", 32'(id_valid), 32'd0);
    tick();
    drive(0, 0, '0);
    chk("s1_valid", 32'(id_valid), 32'd1);
    chk("s1_pc", id_pc, 32'h0);
    chk("s1_opcode", 32'(id_opcode), 32'h13);
    chk("s1_instr", id_instr, 32'h00A0_0093);
    tick();
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, '0);
      chk("s1_bubble", 32'(id_valid), 32'd0);
      tick();
      drive(0, 0, '0);
      chk("s1_seq_valid", 32'(id_valid), 32'd1);
      chk("s1_seq_pc", id_pc, 32'(4 * k));
      tick();
    end

    // Response arrives under stall: skid, then release
    wait_until(3, 1, 20, "s2");
    hold_pc = id_pc;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, '0);
      chk("s2_req_low", 32'(imem_req), 32'd0);
      chk("s2_valid", 32'(id_valid), 32'd1);
      chk("s2_pc_hold", id_pc, hold_pc);
      tick();
    end
    drive(0, 0, '0);
    chk("s2_hold_req", 32'(imem_req), 32'd0);
    chk("s2_pc_hold2", id_pc, hold_pc);
    tick();
    drive(0, 0, '0);
    chk("s2_skid_valid", 32'(id_valid), 32'd1);
    chk("s2_skid_pc", id_pc, hold_pc + 32'd4);
    chk("s2_skid_instr", id_instr, memf(hold_pc + 32'd4));
    tick();

    // Redirect in WAIT, stale response 2 cycles later
    lat_min = 3; lat_max = 3;
    wait_until(1, 0, 20, "s3");
    tick();
    drive(0, 1, 32'h0000_0103);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, '0);
      chk("s3_req_low", 32'(imem_req), 32'd0);
      chk("s3_valid_low", 32'(id_valid), 32'd0);
      tick();
    end
    drive(0, 0, '0);
    chk("s3_req", 32'(imem_req), 32'd1);
    chk("s3_addr", imem_addr, 32'h0000_0100);
    chk("s3_valid_low2", 32'(id_valid), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0);
      chk("s3_valid_low3", 32'(id_valid), 32'd0);
      tick();
    end
    drive(0, 0, '0);
    chk("s3_new_valid", 32'(id_valid), 32'd1);
    chk("s3_new_pc", id_pc, 32'h0000_0100);
    tick();

    // Redirect under stall with live IF/ID; redirect coincident with rvalid
    lat_min = 1; lat_max = 1;
    wait_until(0, 1, 20, "s4a");
    tick();
    drive(1, 1, 32'h0000_0200);
    chk("s4_held", 32'(id_valid), 32'd1);
    tick();
    drive(0, 0, '0);
    chk("s4_flushed", 32'(id_valid), 32'd0);
    tick();
    wait_until(1, 0, 20, "s4b");
    tick();
    drive(0, 2, 32'h0000_0300);
    tick();
    drive(0, 0, '0);
    chk("s4_discard_valid", 32'(id_valid), 32'd0);
    chk("s4_refetch_req", 32'(imem_req), 32'd1);
    chk("s4_refetch_addr", imem_addr, 32'h0000_0300);
    tick();

    // PC wrap at top of address space
    drive(0, 1, 32'hFFFF_FFFC);
    tick();
    wait_until(1, 0, 20, "s5");
    chk("s5_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, '0);
    tick();
    drive(0, 0, '0);
    chk("s5_valid", 32'(id_valid), 32'd1);
    chk("s5_pc", id_pc, 32'hFFFF_FFFC);
    chk("s5_wrap_addr", imem_addr, 32'h0);
    tick();

    // Grant withheld 4 cycles
    gnt_pct = 0;
    wait_until(2, 0, 20, "s6");
    rec = imem_addr;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0);
      chk("s6_req_stable", 32'(imem_req), 32'd1);
      chk("s6_addr_stable", imem_addr, rec);
      tick();
    end

    // Reset in WAIT, then a late response
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    wait_until(1, 0, 20, "s7");
    tick();
    reset = 1'b1; keep_on_reset = 1; gnt_pct = 0;
    drive(0, 0, '0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0);
      chk("s7_req", 32'(imem_req), 32'd1);
      chk("s7_addr", imem_addr, TB_RESET_PC);
      chk("s7_valid_low", 32'(id_valid), 32'd0);
      tick();
    end
    gnt_pct = 100; keep_on_reset = 0; lat_min = 1; lat_max = 1;
    wait_until(0, 0, 20, "s7b");
    chk("s7_restart_pc", id_pc, TB_RESET_PC);
    tick();

    // Randomized traffic
    gnt_pct = 70; lat_min = 1; lat_max = 3; spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(9, 0) < 3);
      rd  = ($urandom_range(24, 0) == 0) ? 1 : 0;
      rpc = $urandom;
      if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFFD;
      reset = ($urandom_range(199, 0) == 0);
      drive(st, rd, rpc);
      tick();
    end
    reset = 1'b0;
    drive(0, 0, '0);
    tick();

    chk("deliveries_seen", 32'(n_deliv > 100), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address.
REQ-003 The ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid; arrives one or more cycles after grant
- imem_rdata  in  32  fetched instruction
- stall  in  1  decode stage cannot accept
- redirect_valid  in  1  branch/jump redirect from execute
- redirect_pc  in  32  redirect target
- id_valid  out  1  IF/ID register holds a live instruction
- id_pc  out  32  PC of id_instr
- id_instr  out  32  instruction to decode/immediate generation
- id_opcode  out  7  id_instr[6:0], combinational

Function
REQ-004 The FSM SHALL have the states FETCH, WAIT and HOLD, with at most one memory request outstanding.
REQ-005 imem_req SHALL equal (state==FETCH && !redirect_valid), and imem_addr SHALL equal pc.
REQ-006 While imem_req is high and imem_gnt is low, imem_addr SHALL remain stable.
REQ-007 In FETCH, when imem_req && imem_gnt: pend_pc<=pc, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), and the FSM SHALL go to WAIT.
REQ-008 In WAIT with imem_rvalid and drop==0: if (!id_valid || !stall), the block SHALL load id_instr<=imem_rdata, id_pc<=pend_pc, id_valid<=1 and go to FETCH; otherwise it SHALL load the skid register {imem_rdata, pend_pc} and go to HOLD.
REQ-009 In WAIT with imem_rvalid and drop==1, the response SHALL be discarded, drop cleared, and the FSM SHALL go to FETCH.
REQ-010 In HOLD with stall==0, the skid contents SHALL move to id_*, id_valid<=1, and the FSM SHALL go to FETCH; in HOLD, imem_req SHALL be 0.
REQ-011 When stall==0 and no instruction is delivered that cycle, id_valid SHALL go to 0 (bubble), and id_instr/id_pc SHALL hold their values.
REQ-012 When stall==1 and id_valid==1, all id_* registers SHALL hold.
REQ-013 redirect_valid SHALL take priority over stall and all other events:
- pc<=redirect_pc with bits [1:0] forced to 0
- id_valid<=0 next cycle
- in FETCH: no request is issued that cycle
- in WAIT: drop<=1, or if imem_rvalid is high the same cycle, the response is discarded and the FSM goes to FETCH
- in HOLD: the skid is discarded and the FSM goes to FETCH
REQ-014 If imem_rvalid is asserted outside WAIT, it SHALL be ignored.
REQ-015 The latency from grant to id_valid SHALL be (response latency + 1) cycles when not stalled.

Reset
REQ-016 On reset the block SHALL set pc=RESET_PC, state=FETCH, drop=0, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP), skid=0, and imem_req SHALL be 1 on the first cycle after reset deasserts.
REQ-017 Reset asserted mid-transaction SHALL abandon any outstanding request, and a late imem_rvalid after reset SHALL be ignored.

Structure
REQ-018 A shared package fetch_pkg SHALL hold the state enum, the NOP constant 32'h0000_0013, the OPCODE_W=7 constant and the default RESET_PC.
REQ-019 The block SHALL have no sub-module; the PC, FSM, skid and IF/ID registers live in instr_fetch.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- Reset release, gnt always 1, rvalid 1 cycle after grant, rdata=32'h00A00093 at addr 0 -> id_valid=1, id_pc=0, id_opcode=7'b0010011 two cycles after the first request; subsequent id_pc values 4, 8, 12.
- stall=1 for 3 cycles while a response arrives -> FSM in HOLD, imem_req=0, id_* unchanged; on stall release the skid instruction appears next cycle, no loss, no duplication.
- Redirect to 32'h0000_0103 while in WAIT, response arriving 2 cycles later -> stale response dropped, next imem_addr=32'h0000_0100, id_valid=0 until the new instruction arrives.
- Redirect with stall=1 and id_valid=1 -> id_valid=0 next cycle; redirect asserted in the same cycle as rvalid -> data discarded.
- pc=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
- imem_gnt held low for 4 cycles -> imem_req and imem_addr stable throughout; reset asserted in WAIT followed by a late rvalid -> ignored, fetch restarts at RESET_PC.
